io_bus_arbiter: RTL and testbench



---
 rtl/io_bus_arbiter_pkg.sv | 27 ++
 rtl/io_bus_arbiter_rr_arbiter2.sv | 44 ++++
 rtl/io_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_io_bus_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_arbiter_pkg.sv
// Shared definitions for the two-master I/O register bus arbiter:
// FSM state encoding, slave read-latency bounds and the wait-counter helper.
package io_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
  localparam int CNT_W      = 2;

  // Wait-counter load value (RD_LAT-1), clamped to the legal latency range.
  function automatic logic [CNT_W-1:0] wait_load(input int rd_lat);
    if (rd_lat <= RD_LAT_MIN) begin
      return {CNT_W{1'b0}};
    end else if (rd_lat >= RD_LAT_MAX) begin
      return CNT_W'(RD_LAT_MAX - 1);
    end else begin
      return CNT_W'(rd_lat - 1);
    end
  endfunction

endpackage

// File: rtl/io_bus_arbiter_rr_arbiter2.sv
// Two-input round-robin grant. On a tie the master that did not win last
// time is granted; last_grant resets to 1 so master 0 wins the first tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic       o_grant,
  output logic       o_valid
);

  logic r_last_grant;

  // Grant decision from the current requests and the previous winner.
  always_comb begin
    o_grant = 1'b0;
    o_valid = 1'b0;
    if (i_req == 2'b11) begin
      o_grant = ~r_last_grant;
      o_valid = 1'b1;
    end else if (i_req[1]) begin
      o_grant = 1'b1;
      o_valid = 1'b1;
    end else if (i_req[0]) begin
      o_grant = 1'b0;
      o_valid = 1'b1;
    end else begin
      o_grant = 1'b0;
      o_valid = 1'b0;
    end
  end

  // Remember the winner whenever a grant is actually taken.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_last_grant <= 1'b1;
    end else if (i_update) begin
      r_last_grant <= o_grant;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master arbiter for the SoC I/O register bus. Each transfer runs
// IDLE(grant) -> ISSUE(bus_en) -> WAIT x (RD_LAT-1) -> ACK(capture bus_dout);
// the ack pulse and read data appear registered in the following IDLE cycle.
module io_bus_arbiter
  import io_bus_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_din,
  input  logic [3:0]        m0_we,
  output logic              m0_ack,
  output logic [31:0]       m0_dout,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_din,
  input  logic [3:0]        m1_we,
  output logic              m1_ack,
  output logic [31:0]       m1_dout,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_din,
  output logic [3:0]        bus_we,
  output logic              bus_en,
  input  logic [31:0]       bus_dout,
  output logic              owner
);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]  r_bus_addr, w_bus_addr_nxt;
  logic [31:0]        r_bus_din, w_bus_din_nxt;
  logic [3:0]         r_bus_we, w_bus_we_nxt;
  logic               r_bus_en, w_bus_en_nxt;
  logic               r_owner, w_owner_nxt;
  logic               r_m0_ack, w_m0_ack_nxt;
  logic               r_m1_ack, w_m1_ack_nxt;
  logic [31:0]        r_m0_dout, w_m0_dout_nxt;
  logic [31:0]        r_m1_dout, w_m1_dout_nxt;
  logic               w_grant, w_valid, w_update;

  rr_arbiter2 u_rr (
    .clk      (clk),
    .rstn     (rstn),
    .i_req    ({m1_req, m0_req}),
    .i_update (w_update),
    .o_grant  (w_grant),
    .o_valid  (w_valid)
  );

  // Next-state and next-output logic; requests are only looked at in IDLE.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_bus_addr_nxt = r_bus_addr;
    w_bus_din_nxt  = r_bus_din;
    w_bus_we_nxt   = r_bus_we;
    w_bus_en_nxt   = 1'b0;
    w_owner_nxt    = r_owner;
    w_m0_ack_nxt   = 1'b0;
    w_m1_ack_nxt   = 1'b0;
    w_m0_dout_nxt  = r_m0_dout;
    w_m1_dout_nxt  = r_m1_dout;
    w_update       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_valid) begin
          w_update     = 1'b1;
          w_owner_nxt  = w_grant;
          w_bus_en_nxt = 1'b1;
          w_state_nxt  = ST_ISSUE;
          if (w_grant) begin
            w_bus_addr_nxt = m1_addr;
            w_bus_din_nxt  = m1_din;
            w_bus_we_nxt   = m1_we;
          end else begin
            w_bus_addr_nxt = m0_addr;
            w_bus_din_nxt  = m0_din;
            w_bus_we_nxt   = m0_we;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        w_cnt_nxt = wait_load(RD_LAT);
        if (RD_LAT > 1) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_ACK;
        end
      end
      ST_WAIT: begin
        if (r_cnt <= 2'd1) begin
          w_cnt_nxt   = 2'd0;
          w_state_nxt = ST_ACK;
        end else begin
          w_cnt_nxt   = r_cnt - 2'd1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_ACK: begin
        w_bus_we_nxt = 4'd0;
        w_state_nxt  = ST_IDLE;
        if (r_owner) begin
          w_m1_dout_nxt = bus_dout;
          w_m1_ack_nxt  = 1'b1;
        end else begin
          w_m0_dout_nxt = bus_dout;
          w_m0_ack_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_cnt_nxt    = 2'd0;
        w_bus_we_nxt = 4'd0;
      end
    endcase
  end

  // State and registered-output update; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 2'd0;
      r_bus_addr <= {ADDR_W{1'b0}};
      r_bus_din  <= 32'd0;
      r_bus_we   <= 4'd0;
      r_bus_en   <= 1'b0;
      r_owner    <= 1'b0;
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_m0_dout  <= 32'd0;
      r_m1_dout  <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bus_addr <= w_bus_addr_nxt;
      r_bus_din  <= w_bus_din_nxt;
      r_bus_we   <= w_bus_we_nxt;
      r_bus_en   <= w_bus_en_nxt;
      r_owner    <= w_owner_nxt;
      r_m0_ack   <= w_m0_ack_nxt;
      r_m1_ack   <= w_m1_ack_nxt;
      r_m0_dout  <= w_m0_dout_nxt;
      r_m1_dout  <= w_m1_dout_nxt;
    end
  end

  assign bus_addr = r_bus_addr;
  assign bus_din  = r_bus_din;
  assign bus_we   = r_bus_we;
  assign bus_en   = r_bus_en;
  assign owner    = r_owner;
  assign m0_ack   = r_m0_ack;
  assign m1_ack   = r_m1_ack;
  assign m0_dout  = r_m0_dout;
  assign m1_dout  = r_m1_dout;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: one instance with RD_LAT=1 (d1_*) and one
// with RD_LAT=3 (d3_*) share clock, reset and master inputs; each has its own
// registered-read slave model.
module tb_io_bus_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m0_din, m1_addr, m1_din;
  logic [3:0]  m0_we, m1_we;

  logic        d1_m0_ack, d1_m1_ack, d1_bus_en, d1_owner;
  logic [31:0] d1_m0_dout, d1_m1_dout, d1_bus_addr, d1_bus_din, d1_bus_dout;
  logic [3:0]  d1_bus_we;
  logic        d3_m0_ack, d3_m1_ack, d3_bus_en, d3_owner;
  logic [31:0] d3_m0_dout, d3_m1_dout, d3_bus_addr, d3_bus_din, d3_bus_dout;
  logic [3:0]  d3_bus_we;

  logic [31:0] s1;
  logic [31:0] s3 [0:2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  io_bus_arbiter #(.RD_LAT(1), .ADDR_W(32)) u_d1 (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_din(m0_din), .m0_we(m0_we),
    .m0_ack(d1_m0_ack), .m0_dout(d1_m0_dout),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_din(m1_din), .m1_we(m1_we),
    .m1_ack(d1_m1_ack), .m1_dout(d1_m1_dout),
    .bus_addr(d1_bus_addr), .bus_din(d1_bus_din), .bus_we(d1_bus_we),
    .bus_en(d1_bus_en), .bus_dout(d1_bus_dout), .owner(d1_owner)
  );

  io_bus_arbiter #(.RD_LAT(3), .ADDR_W(32)) u_d3 (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_din(m0_din), .m0_we(m0_we),
    .m0_ack(d3_m0_ack), .m0_dout(d3_m0_dout),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_din(m1_din), .m1_we(m1_we),
    .m1_ack(d3_m1_ack), .m1_dout(d3_m1_dout),
    .bus_addr(d3_bus_addr), .bus_din(d3_bus_din), .bus_we(d3_bus_we),
    .bus_en(d3_bus_en), .bus_dout(d3_bus_dout), .owner(d3_owner)
  );

  // Slave register contents; writes return zero read data.
  function automatic logic [31:0] slv_data(input logic [31:0] a, input logic [3:0] we);
    if (we != 4'd0) return 32'h0;
    case (a)
      32'h00:  return 32'h0000A5A5;
      32'h04:  return 32'h00C0FFEE;
      32'h08:  return 32'hDEADBEEF;
      32'h10:  return 32'h12345678;
      default: return 32'h0BAD0BAD;
    endcase
  endfunction

  // RD_LAT=1 slave: data valid only in the cycle after bus_en.
  always @(posedge clk) begin
    if (!rstn) s1 <= 32'h0;
    else s1 <= d1_bus_en ? slv_data(d1_bus_addr, d1_bus_we) : 32'h0;
  end
  assign d1_bus_dout = s1;

  // RD_LAT=3 slave: three-stage pipeline, data valid for exactly one cycle.
  always @(posedge clk) begin
    if (!rstn) begin
      s3[0] <= 32'h0; s3[1] <= 32'h0; s3[2] <= 32'h0;
    end else begin
      s3[0] <= d3_bus_en ? slv_data(d3_bus_addr, d3_bus_we) : 32'h0;
      s3[1] <= s3[0];
      s3[2] <= s3[1];
    end
  end
  assign d3_bus_dout = s3[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_masters();
    m0_req = 1'b0; m0_addr = 32'h0; m0_din = 32'h0; m0_we = 4'h0;
    m1_req = 1'b0; m1_addr = 32'h0; m1_din = 32'h0; m1_we = 4'h0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle_masters();
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h44; m0_din = 32'hFFFF; m0_we = 4'hF;
    m1_req = 1'b1; m1_addr = 32'h48; m1_din = 32'hEEEE; m1_we = 4'hF;
    tick();
    tick();
    checks++; if (d1_bus_en !== 1'b0) begin errors++; $display("FAIL rst_bus_en got %0h want 0", d1_bus_en); end
    checks++; if (d1_bus_we !== 4'h0) begin errors++; $display("FAIL rst_bus_we got %0h want 0", d1_bus_we); end
    checks++; if (d1_bus_addr !== 32'h0) begin errors++; $display("FAIL rst_bus_addr got %0h want 0", d1_bus_addr); end
    checks++; if (d1_bus_din !== 32'h0) begin errors++; $display("FAIL rst_bus_din got %0h want 0", d1_bus_din); end
    checks++; if (d1_owner !== 1'b0) begin errors++; $display("FAIL rst_owner got %0h want 0", d1_owner); end
    checks++; if ({d1_m0_ack, d1_m1_ack} !== 2'b00) begin errors++; $display("FAIL rst_acks got %0b want 00", {d1_m0_ack, d1_m1_ack}); end
    checks++; if (d1_m0_dout !== 32'h0 || d1_m1_dout !== 32'h0) begin errors++; $display("FAIL rst_dout got %0h/%0h want 0/0", d1_m0_dout, d1_m1_dout); end
    checks++; if (d3_bus_en !== 1'b0 || d3_bus_addr !== 32'h0) begin errors++; $display("FAIL rst_d3 got en=%0h addr=%0h want 0/0", d3_bus_en, d3_bus_addr); end
    idle_masters();
  endtask

  task automatic test_single_read();
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h00; m0_we = 4'h0;
    tick();
    checks++; if (d1_bus_en !== 1'b1 || d1_bus_addr !== 32'h0 || d1_bus_we !== 4'h0) begin errors++; $display("FAIL t1_issue got en=%0h addr=%0h we=%0h want 1/0/0", d1_bus_en, d1_bus_addr, d1_bus_we); end
    tick();
    checks++; if (d1_bus_en !== 1'b0 || d1_m0_ack !== 1'b0) begin errors++; $display("FAIL t1_ackstate got en=%0h ack=%0h want 0/0", d1_bus_en, d1_m0_ack); end
    tick();
    checks++; if (d1_m0_ack !== 1'b1 || d1_m0_dout !== 32'h0000A5A5) begin errors++; $display("FAIL t1_ack got ack=%0h dout=%0h want 1/0000a5a5", d1_m0_ack, d1_m0_dout); end
    checks++; if (d1_m1_ack !== 1'b0) begin errors++; $display("FAIL t1_m1_ack got %0h want 0", d1_m1_ack); end
    m0_req = 1'b0;
    tick();
    checks++; if (d1_m0_ack !== 1'b0 || d1_bus_en !== 1'b0) begin errors++; $display("FAIL t1_after got ack=%0h en=%0h want 0/0", d1_m0_ack, d1_bus_en); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h0C; m0_din = 32'h00001234; m0_we = 4'hF;
    m1_req = 1'b1; m1_addr = 32'h04; m1_din = 32'h0; m1_we = 4'h0;
    tick();
    checks++; if (d1_bus_en !== 1'b1 || d1_owner !== 1'b0 || d1_bus_we !== 4'hF || d1_bus_din !== 32'h1234 || d1_bus_addr !== 32'h0C) begin errors++; $display("FAIL t2_m0_issue got en=%0h own=%0h we=%0h din=%0h addr=%0h want 1/0/f/1234/c", d1_bus_en, d1_owner, d1_bus_we, d1_bus_din, d1_bus_addr); end
    tick();
    tick();
    checks++; if (d1_m0_ack !== 1'b1 || d1_m1_ack !== 1'b0 || d1_bus_we !== 4'h0) begin errors++; $display("FAIL t2_m0_ack got m0=%0h m1=%0h we=%0h want 1/0/0", d1_m0_ack, d1_m1_ack, d1_bus_we); end
    m0_req = 1'b0;
    tick();
    checks++; if (d1_bus_en !== 1'b1 || d1_owner !== 1'b1 || d1_bus_addr !== 32'h04 || d1_bus_we !== 4'h0) begin errors++; $display("FAIL t2_m1_issue got en=%0h own=%0h addr=%0h we=%0h want 1/1/4/0", d1_bus_en, d1_owner, d1_bus_addr, d1_bus_we); end
    tick();
    checks++; if (d1_m1_ack !== 1'b0) begin errors++; $display("FAIL t2_m1_early got %0h want 0", d1_m1_ack); end
    tick();
    checks++; if (d1_m1_ack !== 1'b1 || d1_m1_dout !== 32'h00C0FFEE || d1_m0_ack !== 1'b0) begin errors++; $display("FAIL t2_m1_ack got ack=%0h dout=%0h m0=%0h want 1/00c0ffee/0", d1_m1_ack, d1_m1_dout, d1_m0_ack); end
    checks++; if (d1_m0_dout !== 32'h0) begin errors++; $display("FAIL t2_m0_hold got %0h want 0", d1_m0_dout); end
    m1_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int n0 = 0;
    int n1 = 0;
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h00; m0_we = 4'h0;
    m1_req = 1'b1; m1_addr = 32'h04; m1_we = 4'h0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n0 += int'(d1_m0_ack); n1 += int'(d1_m1_ack);
      checks++; if (d1_bus_en !== 1'b1 || d1_owner !== ((i % 2 == 1) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL t3_grant%0d got en=%0h own=%0h want 1/%0d", i, d1_bus_en, d1_owner, i % 2); end
      tick();
      n0 += int'(d1_m0_ack); n1 += int'(d1_m1_ack);
      tick();
      n0 += int'(d1_m0_ack); n1 += int'(d1_m1_ack);
      checks++; if ({d1_m1_ack, d1_m0_ack} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL t3_ack%0d got m1m0=%0b want owner %0d only", i, {d1_m1_ack, d1_m0_ack}, i % 2); end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    n0 += int'(d1_m0_ack); n1 += int'(d1_m1_ack);
    checks++; if (n0 != 3 || n1 != 3) begin errors++; $display("FAIL t3_counts got %0d/%0d want 3/3", n0, n1); end
  endtask

  task automatic test_long_latency();
    do_reset();
    m1_req = 1'b1; m1_addr = 32'h08; m1_we = 4'h0;
    tick();
    checks++; if (d3_bus_en !== 1'b1 || d3_owner !== 1'b1 || d3_bus_addr !== 32'h08) begin errors++; $display("FAIL t4_issue got en=%0h own=%0h addr=%0h want 1/1/8", d3_bus_en, d3_owner, d3_bus_addr); end
    tick();
    checks++; if (d3_bus_en !== 1'b0 || d3_m1_ack !== 1'b0) begin errors++; $display("FAIL t4_wait1 got en=%0h ack=%0h want 0/0", d3_bus_en, d3_m1_ack); end
    tick();
    checks++; if (d3_bus_en !== 1'b0 || d3_m1_ack !== 1'b0) begin errors++; $display("FAIL t4_wait2 got en=%0h ack=%0h want 0/0", d3_bus_en, d3_m1_ack); end
    tick();
    checks++; if (d3_bus_en !== 1'b0 || d3_m1_ack !== 1'b0) begin errors++; $display("FAIL t4_ackstate got en=%0h ack=%0h want 0/0", d3_bus_en, d3_m1_ack); end
    tick();
    checks++; if (d3_m1_ack !== 1'b1 || d3_m1_dout !== 32'hDEADBEEF || d3_m0_ack !== 1'b0) begin errors++; $display("FAIL t4_ack got ack=%0h dout=%0h m0=%0h want 1/deadbeef/0", d3_m1_ack, d3_m1_dout, d3_m0_ack); end
    m1_req = 1'b0;
    tick();
    checks++; if (d3_m1_ack !== 1'b0) begin errors++; $display("FAIL t4_pulse got %0h want 0", d3_m1_ack); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h10; m0_we = 4'h0;
    tick();
    checks++; if (d3_bus_en !== 1'b1 || d3_bus_addr !== 32'h10) begin errors++; $display("FAIL t5_issue got en=%0h addr=%0h want 1/10", d3_bus_en, d3_bus_addr); end
    tick();
    rstn = 1'b0;
    tick();
    checks++; if (d3_bus_en !== 1'b0 || d3_bus_addr !== 32'h0 || d3_owner !== 1'b0 || d3_m0_ack !== 1'b0 || d3_m0_dout !== 32'h0 || d3_bus_we !== 4'h0) begin errors++; $display("FAIL t5_reset got en=%0h addr=%0h own=%0h ack=%0h dout=%0h we=%0h want all 0", d3_bus_en, d3_bus_addr, d3_owner, d3_m0_ack, d3_m0_dout, d3_bus_we); end
    m0_req = 1'b0; m0_addr = 32'h0;
    m1_req = 1'b1; m1_addr = 32'h04; m1_we = 4'h0;
    rstn = 1'b1;
    tick();
    checks++; if (d3_bus_en !== 1'b1 || d3_owner !== 1'b1 || d3_bus_addr !== 32'h04) begin errors++; $display("FAIL t5_m1_grant got en=%0h own=%0h addr=%0h want 1/1/4", d3_bus_en, d3_owner, d3_bus_addr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (d3_m0_ack !== 1'b0 || d3_m1_ack !== 1'b0) begin errors++; $display("FAIL t5_noack%0d got m0=%0h m1=%0h want 0/0", i, d3_m0_ack, d3_m1_ack); end
    end
    tick();
    checks++; if (d3_m1_ack !== 1'b1 || d3_m1_dout !== 32'h00C0FFEE || d3_m0_ack !== 1'b0) begin errors++; $display("FAIL t5_m1_ack got ack=%0h dout=%0h m0=%0h want 1/00c0ffee/0", d3_m1_ack, d3_m1_dout, d3_m0_ack); end
    m0_req = 1'b1; m0_addr = 32'h00; m0_we = 4'h0;
    tick();
    checks++; if (d3_bus_en !== 1'b1 || d3_owner !== 1'b0 || d3_bus_addr !== 32'h00) begin errors++; $display("FAIL t5_tie got en=%0h own=%0h addr=%0h want 1/0/0", d3_bus_en, d3_owner, d3_bus_addr); end
    tick(); tick(); tick();
    tick();
    checks++; if (d3_m0_ack !== 1'b1 || d3_m0_dout !== 32'h0000A5A5) begin errors++; $display("FAIL t5_m0_ack got ack=%0h dout=%0h want 1/0000a5a5", d3_m0_ack, d3_m0_dout); end
    idle_masters();
    tick();
  endtask

  task automatic test_partial_write();
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h00; m0_we = 4'h0;
    tick(); tick(); tick();
    checks++; if (d1_m0_ack !== 1'b1 || d1_m0_dout !== 32'h0000A5A5) begin errors++; $display("FAIL t6_pre got ack=%0h dout=%0h want 1/0000a5a5", d1_m0_ack, d1_m0_dout); end
    m0_req = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h24; m1_din = 32'h00AB0000; m1_we = 4'b0100;
    tick();
    checks++; if (d1_bus_en !== 1'b1 || d1_bus_we !== 4'b0100 || d1_bus_addr !== 32'h24 || d1_bus_din !== 32'h00AB0000) begin errors++; $display("FAIL t6_issue got en=%0h we=%0h addr=%0h din=%0h want 1/4/24/00ab0000", d1_bus_en, d1_bus_we, d1_bus_addr, d1_bus_din); end
    tick();
    tick();
    checks++; if (d1_m1_ack !== 1'b1 || d1_bus_we !== 4'h0 || d1_bus_addr !== 32'h24) begin errors++; $display("FAIL t6_ack got ack=%0h we=%0h addr=%0h want 1/0/24", d1_m1_ack, d1_bus_we, d1_bus_addr); end
    checks++; if (d1_m0_ack !== 1'b0 || d1_m0_dout !== 32'h0000A5A5) begin errors++; $display("FAIL t6_m0_hold got ack=%0h dout=%0h want 0/0000a5a5", d1_m0_ack, d1_m0_dout); end
    idle_masters();
    tick();
    checks++; if (d1_bus_en !== 1'b0 || d1_bus_we !== 4'h0 || d1_m1_ack !== 1'b0 || d1_bus_din !== 32'h00AB0000 || d1_owner !== 1'b1) begin errors++; $display("FAIL t6_idle got en=%0h we=%0h ack=%0h din=%0h own=%0h want 0/0/0/00ab0000/1", d1_bus_en, d1_bus_we, d1_m1_ack, d1_bus_din, d1_owner); end
  endtask

  initial begin
    rstn = 1'b0;
    idle_masters();
    test_reset();
    test_single_read();
    test_simultaneous();
    test_back_to_back();
    test_long_latency();
    test_reset_midflight();
    test_partial_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
